qam16_tx_framer: RTL

Upstream stage of the 16-QAM transmitter. It accepts 8-bit samples from the ADC capture logic, buffers them in a FIFO and assembles frames: preamble, sync word, payload and an optional CRC. It emits one 4-bit symbol per symbol tick to the code-mapping stage (I/Q level mapper).
The block runs entirely in the 50 MHz domain, with symbol timing supplied as a single-cycle enable.

---
 rtl/qam16_tx_pkg.sv | 36 +++
 rtl/qam16_tx_framer_if.sv | 34 +++
 rtl/qam16_byte_fifo.sv | 63 ++++++
 rtl/qam16_tx_framer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/qam16_tx_pkg.sv
// ============================================================================
// Module : qam16_tx_pkg
// Brief  : Shared types, symbol constants and the CRC-8 helper for the framer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qam16_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_PAY_HI   = 3'd3,
    ST_PAY_LO   = 3'd4,
    ST_CRC_HI   = 3'd5,
    ST_CRC_LO   = 3'd6
  } fsm_state_e;

  localparam logic [3:0] c_pre_sym_a = 4'h3;
  localparam logic [3:0] c_pre_sym_b = 4'hC;
  localparam logic [7:0] c_crc8_poly = 8'h07;

  // MSB-first CRC-8, no reflection, no final XOR
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ c_crc8_poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qam16_tx_framer_if.sv
// ============================================================================
// Module : qam16_tx_framer_if
// Brief  : Sample-in / symbol-out bundle between ADC capture, framer and mapper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface qam16_tx_framer_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             sym_tick;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       sym_out;
  logic             sym_valid;
  logic             frame_start;
  logic [LVL_W-1:0] fifo_level;

  modport slave (
    input  sym_tick, in_data, in_valid,
    output in_ready, sym_out, sym_valid, frame_start, fifo_level
  );

  modport master (
    output sym_tick, in_data, in_valid,
    input  in_ready, sym_out, sym_valid, frame_start, fifo_level
  );

endinterface

`default_nettype wire

// File: rtl/qam16_byte_fifo.sv
// ============================================================================
// Module : qam16_byte_fifo
// Brief  : Single-clock byte FIFO, extra-MSB pointers, registered occupancy.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qam16_byte_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          do_wr, do_rd;

  always_comb begin
    full     = (level_q == PW'(FIFO_DEPTH));
    do_wr    = wr_en && !full;
    do_rd    = rd_en && (level_q != '0);
    wr_ptr_d = wr_ptr_q + PW'(do_wr);
    rd_ptr_d = rd_ptr_q + PW'(do_rd);
    level_d  = wr_ptr_d - rd_ptr_d;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: pointers define which entries are live
  always_ff @(posedge CLK) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/qam16_tx_framer.sv
// ============================================================================
// Module : qam16_tx_framer
// Brief  : Buffers ADC bytes and emits preamble/sync/payload[/CRC] nibbles per
//          symbol tick. CRC-8 trailer compiled in with QAM16_FRAMER_CRC8_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qam16_tx_framer
  import qam16_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 16,
  parameter int          PAYLOAD_BYTES = 8,
  parameter int          PREAMBLE_SYMS = 8,
  parameter logic [15:0] SYNC_WORD     = 16'hA5F0,
  parameter logic [3:0]  IDLE_SYM      = 4'h0
) (
  input  logic               CLK,
  input  logic               RST,
  qam16_tx_framer_if.slave   bus
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = (PREAMBLE_SYMS > 4) ? $clog2(PREAMBLE_SYMS) : 2;
  localparam int BW = $clog2(PAYLOAD_BYTES + 1);

  fsm_state_e    state_q, state_d;
  logic [SW-1:0] sym_cnt_q, sym_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [3:0]    lo_nib_q, lo_nib_d;
  logic [3:0]    sym_out_q, sym_out_d;
  logic          sym_valid_q, sym_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          pop;
  logic [7:0]    fifo_rd_data;
  logic          fifo_full;
  logic [LW-1:0] fifo_level;
  logic [7:0]    crc_q, crc_d;

  qam16_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (bus.in_valid),
    .wr_data (bus.in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  always_comb begin
    state_d       = state_q;
    sym_cnt_d     = sym_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    lo_nib_d      = lo_nib_q;
    sym_out_d     = sym_out_q;
    sym_valid_d   = sym_valid_q;
    frame_start_d = 1'b0;
    crc_d         = crc_q;
    pop           = 1'b0;
    if (bus.sym_tick) begin
      sym_valid_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          // Only start once the whole payload is buffered: no underflow mid-frame
          if (fifo_level >= LW'(PAYLOAD_BYTES)) begin
            sym_out_d     = c_pre_sym_a;
            frame_start_d = 1'b1;
            sym_cnt_d     = SW'(1);
            byte_cnt_d    = '0;
            crc_d         = '0;
            state_d       = ST_PREAMBLE;
          end else begin
            sym_out_d   = IDLE_SYM;
            sym_valid_d = 1'b0;
          end
        end
        ST_PREAMBLE: begin
          sym_out_d = sym_cnt_q[0] ? c_pre_sym_b : c_pre_sym_a;
          if (sym_cnt_q == SW'(PREAMBLE_SYMS - 1)) begin
            sym_cnt_d = '0;
            state_d   = ST_SYNC;
          end else begin
            sym_cnt_d = sym_cnt_q + SW'(1);
          end
        end
        ST_SYNC: begin
          case (sym_cnt_q[1:0])
            2'd0:    sym_out_d = SYNC_WORD[15:12];
            2'd1:    sym_out_d = SYNC_WORD[11:8];
            2'd2:    sym_out_d = SYNC_WORD[7:4];
            default: sym_out_d = SYNC_WORD[3:0];
          endcase
          if (sym_cnt_q[1:0] == 2'd3) begin
            sym_cnt_d = '0;
            state_d   = ST_PAY_HI;
          end else begin
            sym_cnt_d = sym_cnt_q + SW'(1);
          end
        end
        ST_PAY_HI: begin
          pop       = 1'b1;
          sym_out_d = fifo_rd_data[7:4];
          lo_nib_d  = fifo_rd_data[3:0];
          crc_d     = crc8_byte(crc_q, fifo_rd_data);
          state_d   = ST_PAY_LO;
        end
        ST_PAY_LO: begin
          sym_out_d = lo_nib_q;
          if (byte_cnt_q == BW'(PAYLOAD_BYTES - 1)) begin
`ifdef QAM16_FRAMER_CRC8_EN
            state_d = ST_CRC_HI;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
            state_d    = ST_PAY_HI;
          end
        end
`ifdef QAM16_FRAMER_CRC8_EN
        ST_CRC_HI: begin
          sym_out_d = crc_q[7:4];
          state_d   = ST_CRC_LO;
        end
        ST_CRC_LO: begin
          sym_out_d = crc_q[3:0];
          state_d   = ST_IDLE;
        end
`endif
        default: begin
          sym_out_d   = IDLE_SYM;
          sym_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      sym_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      lo_nib_q      <= '0;
      sym_out_q     <= IDLE_SYM;
      sym_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sym_cnt_q     <= sym_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      lo_nib_q      <= lo_nib_d;
      sym_out_q     <= sym_out_d;
      sym_valid_q   <= sym_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef QAM16_FRAMER_CRC8_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end
`else
  assign crc_q = '0;
`endif

  assign bus.in_ready    = !fifo_full;
  assign bus.sym_out     = sym_out_q;
  assign bus.sym_valid   = sym_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.fifo_level  = fifo_level;

endmodule

`default_nettype wire
